// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: skips start-up frames, assembles sensor bytes into pixels
// and emits a one-cycle write strobe for pixels inside a per-frame crop window.
module ov5640_capture #(
  parameter int PIX_BYTES   = 2,
  parameter int SKIP_FRAMES = 10,
  parameter int CNT_W       = 12,
  parameter int MSB_FIRST   = 1
) (
  input  logic                   ov5640_pclk,
  input  logic                   s_rst_n,
  input  logic                   ov5640_href,
  input  logic                   ov5640_vsync,
  input  logic [7:0]             ov5640_data,
  input  logic                   cap_en,
  input  logic [CNT_W-1:0]       cfg_x_start,
  input  logic [CNT_W-1:0]       cfg_x_size,
  input  logic [CNT_W-1:0]       cfg_y_start,
  input  logic [CNT_W-1:0]       cfg_y_size,
  output logic [8*PIX_BYTES-1:0] m_data,
  output logic                   m_wr_en,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int PW = 8 * PIX_BYTES;
  localparam int BW = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam logic [BW-1:0]    LAST_IDX = BW'(PIX_BYTES - 1);
  localparam logic [7:0]       SKIP_N   = 8'(SKIP_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   END_ONE  = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    IDLE    = 2'd1,
    WAIT_VS = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       skip_cnt_q, skip_cnt_d;
  logic             vs_prev_q, vs_prev_d;
  logic             href_prev_q, href_prev_d;
  logic [BW-1:0]    byte_idx_q, byte_idx_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] x_start_q, x_start_d, x_size_q, x_size_d;
  logic [CNT_W-1:0] y_start_q, y_start_d, y_size_q, y_size_d;
  logic             sof_pend_q, sof_pend_d;
  logic [PW-1:0]    m_data_q, m_data_d;
  logic             m_wr_en_q, m_wr_en_d, m_sof_q, m_sof_d, m_eol_q, m_eol_d;
  logic             frame_done_q, frame_done_d, busy_q, busy_d;

  logic             vs_pos_s, href_fall_s, last_byte_s, in_win_s, wr_s, eol_hit_s;
  logic [BW-1:0]    byte_pos_s;
  logic [PW-1:0]    pix_asm_s;
  logic [CNT_W:0]   x_end_s, y_end_s;

  // Window test uses the latched (old-frame) counters and config, so a pixel
  // completing on the same edge as vs_pos still belongs to the ending frame.
  always_comb begin
    vs_pos_s    = ov5640_vsync & ~vs_prev_q;
    href_fall_s = href_prev_q & ~ov5640_href;
    last_byte_s = ov5640_href & (byte_idx_q == LAST_IDX);
    byte_pos_s  = (MSB_FIRST != 0) ? (LAST_IDX - byte_idx_q) : byte_idx_q;
    pix_asm_s   = pix_q;
    for (int i = 0; i < PIX_BYTES; i++) begin
      if (byte_pos_s == BW'(i)) begin
        pix_asm_s[8*i +: 8] = ov5640_data;
      end else begin
        pix_asm_s[8*i +: 8] = pix_q[8*i +: 8];
      end
    end
    x_end_s   = {1'b0, x_start_q} + {1'b0, x_size_q};
    y_end_s   = {1'b0, y_start_q} + {1'b0, y_size_q};
    in_win_s  = (x_cnt_q >= x_start_q) && ({1'b0, x_cnt_q} < x_end_s) &&
                (y_cnt_q >= y_start_q) && ({1'b0, y_cnt_q} < y_end_s);
    wr_s      = (state_q == ACTIVE) && last_byte_s && in_win_s;
    eol_hit_s = ({1'b0, x_cnt_q} == (x_end_s - END_ONE));

    vs_prev_d   = ov5640_vsync;
    href_prev_d = ov5640_href;
    if (!ov5640_href) begin
      byte_idx_d = '0;
      pix_d      = pix_q;
    end else if (last_byte_s) begin
      byte_idx_d = '0;
      pix_d      = pix_asm_s;
    end else begin
      byte_idx_d = byte_idx_q + BW'(1);
      pix_d      = pix_asm_s;
    end

    if (href_fall_s) begin
      x_cnt_d = '0;
    end else if (last_byte_s && (x_cnt_q != '1)) begin
      x_cnt_d = x_cnt_q + CNT_ONE;
    end else begin
      x_cnt_d = x_cnt_q;
    end

    if (vs_pos_s) begin
      y_cnt_d   = '0;
      x_start_d = cfg_x_start;
      x_size_d  = cfg_x_size;
      y_start_d = cfg_y_start;
      y_size_d  = cfg_y_size;
    end else begin
      y_cnt_d   = (href_fall_s && (y_cnt_q != '1)) ? (y_cnt_q + CNT_ONE) : y_cnt_q;
      x_start_d = x_start_q;
      x_size_d  = x_size_q;
      y_start_d = y_start_q;
      y_size_d  = y_size_q;
    end

    if (vs_pos_s) begin
      sof_pend_d = 1'b1;
    end else if (wr_s) begin
      sof_pend_d = 1'b0;
    end else begin
      sof_pend_d = sof_pend_q;
    end

    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      SKIP: begin
        if (skip_cnt_q == SKIP_N) begin
          state_d = IDLE;
        end else if (vs_pos_s) begin
          skip_cnt_d = skip_cnt_q + 8'd1;
        end else begin
          skip_cnt_d = skip_cnt_q;
        end
      end
      IDLE: begin
        if (cap_en) state_d = WAIT_VS;
        else        state_d = IDLE;
      end
      WAIT_VS: begin
        if (!cap_en)       state_d = IDLE;
        else if (vs_pos_s) state_d = ACTIVE;
        else               state_d = WAIT_VS;
      end
      ACTIVE: begin
        if (vs_pos_s) begin
          frame_done_d = 1'b1;
          state_d      = cap_en ? ACTIVE : IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = SKIP;
    endcase

    busy_d    = (state_d == ACTIVE);
    m_wr_en_d = wr_s;
    m_sof_d   = wr_s & sof_pend_q;
    m_eol_d   = wr_s & eol_hit_s;
    m_data_d  = wr_s ? pix_asm_s : m_data_q;
  end

  // All state; vs_prev resets high so a vsync already high at release is not an edge.
  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q      <= SKIP;
      skip_cnt_q   <= 8'd0;
      vs_prev_q    <= 1'b1;
      href_prev_q  <= 1'b0;
      byte_idx_q   <= '0;
      pix_q        <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      x_start_q    <= '0;
      x_size_q     <= '0;
      y_start_q    <= '0;
      y_size_q     <= '0;
      sof_pend_q   <= 1'b0;
      m_data_q     <= '0;
      m_wr_en_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eol_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      vs_prev_q    <= vs_prev_d;
      href_prev_q  <= href_prev_d;
      byte_idx_q   <= byte_idx_d;
      pix_q        <= pix_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      x_start_q    <= x_start_d;
      x_size_q     <= x_size_d;
      y_start_q    <= y_start_d;
      y_size_q     <= y_size_d;
      sof_pend_q   <= sof_pend_d;
      m_data_q     <= m_data_d;
      m_wr_en_q    <= m_wr_en_d;
      m_sof_q      <= m_sof_d;
      m_eol_q      <= m_eol_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_wr_en    = m_wr_en_q;
  assign m_sof      = m_sof_q;
  assign m_eol      = m_eol_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ov5640_capture.sv
// Bench for ov5640_capture: drives whole frames and compares captured pixels
// against a frame-level model of skip, window and byte-order rules.
module tb_ov5640_capture;

  localparam int PB   = 2;
  localparam int SKIP = 2;
  localparam int CW   = 12;

  logic          clk = 1'b0;
  logic          rst_n, href, vsync, cap_en;
  logic [7:0]    data;
  logic [CW-1:0] xs, xz, ys, yz;
  logic [15:0]   m_data, l_data;
  logic          m_wr_en, m_sof, m_eol, frame_done, busy;
  logic          l_wr_en, l_sof, l_eol, l_fd, l_busy;

  always #5 clk = ~clk;

  ov5640_capture #(.PIX_BYTES(PB), .SKIP_FRAMES(SKIP), .CNT_W(CW), .MSB_FIRST(1)) dut (
    .ov5640_pclk(clk), .s_rst_n(rst_n), .ov5640_href(href), .ov5640_vsync(vsync),
    .ov5640_data(data), .cap_en(cap_en), .cfg_x_start(xs), .cfg_x_size(xz),
    .cfg_y_start(ys), .cfg_y_size(yz), .m_data(m_data), .m_wr_en(m_wr_en),
    .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done), .busy(busy));

  ov5640_capture #(.PIX_BYTES(PB), .SKIP_FRAMES(SKIP), .CNT_W(CW), .MSB_FIRST(0)) dut_lsb (
    .ov5640_pclk(clk), .s_rst_n(rst_n), .ov5640_href(href), .ov5640_vsync(vsync),
    .ov5640_data(data), .cap_en(cap_en), .cfg_x_start(xs), .cfg_x_size(xz),
    .cfg_y_start(ys), .cfg_y_size(yz), .m_data(l_data), .m_wr_en(l_wr_en),
    .m_sof(l_sof), .m_eol(l_eol), .frame_done(l_fd), .busy(l_busy));

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
  } wr_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  got_q[$], got_l_q[$], exp_q[$];
  int   fd_cnt = 0;
  logic fd_prev = 1'b0;
  logic busy_after_fd = 1'b0;
  int   skip_left;
  bit   prev_cap;
  logic [7:0] line_bytes [8][16];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (m_wr_en) got_q.push_back(wr_t'({m_data, m_sof, m_eol}));
    if (l_wr_en) got_l_q.push_back(wr_t'({l_data, l_sof, l_eol}));
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (fd_prev) busy_after_fd <= busy;
    fd_prev <= frame_done;
  end

  task automatic run_frame(input string name, input int nlines, input int nbytes,
                           input int odd_line, input int drop_line, input bit seq,
                           input int fxs, input int fxz, input int fys, input int fyz);
    bit  cap;
    bit  first;
    int  fd0, nb;
    wr_t e, el;
    if (skip_left > 0) begin
      skip_left--;
      cap = 1'b0;
    end else begin
      cap = cap_en;
    end
    got_q.delete(); got_l_q.delete(); exp_q.delete();
    fd0 = fd_cnt;
    first = 1'b1;
    for (int y = 0; y < nlines; y++) begin
      nb = (y == odd_line) ? nbytes - 1 : nbytes;
      for (int b = 0; b < 16; b++)
        line_bytes[y][b] = seq ? (8'h12 + 8'(b * 34)) : 8'($urandom);
      for (int x = 0; x < nb / PB; x++) begin
        if (cap && x >= fxs && x < fxs + fxz && y >= fys && y < fys + fyz) begin
          e.d   = {line_bytes[y][2*x], line_bytes[y][2*x+1]};
          e.sof = first;
          e.eol = (x == fxs + fxz - 1);
          exp_q.push_back(e);
          first = 1'b0;
        end
      end
    end

    @(negedge clk);
    xs = CW'(fxs); xz = CW'(fxz); ys = CW'(fys); yz = CW'(fyz);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    // Config changes after the frame edge must not affect this frame
    xs = CW'($urandom_range(0, 7)); xz = CW'($urandom_range(0, 7));
    ys = CW'($urandom_range(0, 3)); yz = CW'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    n_checks++;
    if (fd_cnt - fd0 != int'(prev_cap)) begin
      n_fail++;
      $display("FAIL %s frame_done: got %0d pulses expected %0d", name, fd_cnt - fd0, int'(prev_cap));
    end
    if (prev_cap && !cap) begin
      n_checks++;
      if (busy_after_fd !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_after_done: got %b expected 0", name, busy_after_fd);
      end
    end

    for (int y = 0; y < nlines; y++) begin
      nb = (y == odd_line) ? nbytes - 1 : nbytes;
      href = 1'b1;
      for (int b = 0; b < nb; b++) begin
        data = line_bytes[y][b];
        @(negedge clk);
        if (y == 0 && b == 0) begin
          n_checks++;
          if (busy !== cap) begin
            n_fail++;
            $display("FAIL %s busy: got %b expected %b", name, busy, cap);
          end
        end
      end
      href = 1'b0;
      data = 8'h00;
      if (y == drop_line) cap_en = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count_msb: got %0d writes expected %0d", name, got_q.size(), exp_q.size());
    end
    n_checks++;
    if (got_l_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count_lsb: got %0d writes expected %0d", name, got_l_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      el = exp_q[i];
      el.d = {exp_q[i].d[7:0], exp_q[i].d[15:8]};
      if (i < got_q.size()) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s pix%0d_msb: got d=%h sof=%b eol=%b expected d=%h sof=%b eol=%b", name, i,
                   got_q[i].d, got_q[i].sof, got_q[i].eol, exp_q[i].d, exp_q[i].sof, exp_q[i].eol);
        end
      end
      if (i < got_l_q.size()) begin
        n_checks++;
        if (got_l_q[i] !== el) begin
          n_fail++;
          $display("FAIL %s pix%0d_lsb: got d=%h sof=%b eol=%b expected d=%h sof=%b eol=%b", name, i,
                   got_l_q[i].d, got_l_q[i].sof, got_l_q[i].eol, el.d, el.sof, el.eol);
        end
      end
    end
    prev_cap = cap;
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if ({m_data, m_wr_en, m_sof, m_eol, frame_done, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL %s msb_outputs: got %h expected 0", name, {m_data, m_wr_en, m_sof, m_eol, frame_done, busy});
    end
    n_checks++;
    if ({l_data, l_wr_en, l_sof, l_eol, l_fd, l_busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL %s lsb_outputs: got %h expected 0", name, {l_data, l_wr_en, l_sof, l_eol, l_fd, l_busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; href = 1'b0; vsync = 1'b0; cap_en = 1'b1; data = 8'h00;
    xs = '0; xz = '0; ys = '0; yz = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    skip_left = SKIP;
    prev_cap  = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("after_release");
  endtask

  task automatic test_basic();
    run_frame("skip1", 2, 8, -1, -1, 1'b1, 0, 4, 0, 2);
    run_frame("skip2", 2, 8, -1, -1, 1'b1, 0, 4, 0, 2);
    run_frame("basic", 2, 8, -1, -1, 1'b1, 0, 4, 0, 2);
    n_checks++;
    if (got_q.size() != 8) begin
      n_fail++;
      $display("FAIL basic_writes: got %0d expected 8", got_q.size());
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0].d !== 16'h1234 || got_q[0].sof !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_first_msb: got %0d writes, first %h expected 1234 with sof", got_q.size(),
               (got_q.size() > 0) ? got_q[0].d : 16'hxxxx);
    end
    n_checks++;
    if (got_l_q.size() == 0 || got_l_q[0].d !== 16'h3412) begin
      n_fail++;
      $display("FAIL basic_first_lsb: got %0d writes, first %h expected 3412", got_l_q.size(),
               (got_l_q.size() > 0) ? got_l_q[0].d : 16'hxxxx);
    end
  endtask

  task automatic test_window();
    run_frame("window", 4, 16, -1, -1, 1'b0, 2, 3, 1, 1);
    n_checks++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL window_count: got %0d expected 3", got_q.size());
    end
  endtask

  task automatic test_odd_href();
    run_frame("odd_href", 3, 16, 1, -1, 1'b0, 0, 8, 0, 4);
  endtask

  task automatic test_random_windows();
    for (int f = 0; f < 6; f++)
      run_frame("random", $urandom_range(3, 5), 16, -1, -1, 1'b0,
                $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 4), $urandom_range(0, 4));
  endtask

  task automatic test_cap_drop();
    run_frame("cap_drop", 4, 16, -1, 1, 1'b0, 1, 6, 0, 4);
    run_frame("after_drop", 3, 16, -1, -1, 1'b0, 0, 8, 0, 3);
    cap_en = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("reenable", 3, 16, -1, -1, 1'b0, 0, 8, 0, 3);
  endtask

  task automatic test_reset_midline();
    @(negedge clk);
    xs = '0; xz = CW'(4); ys = '0; yz = CW'(2);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    href = 1'b1;
    for (int b = 0; b < 5; b++) begin
      data = 8'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_busy: got %b expected 1", busy);
    end
    vsync = 1'b1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_immediate");
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    href  = 1'b0;
    rst_n = 1'b1;
    skip_left = SKIP;
    prev_cap  = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    run_frame("rst_skip1", 2, 8, -1, -1, 1'b0, 0, 4, 0, 2);
    run_frame("rst_skip2", 2, 8, -1, -1, 1'b0, 0, 4, 0, 2);
    run_frame("rst_resume", 2, 8, -1, -1, 1'b0, 0, 4, 0, 2);
    n_checks++;
    if (got_q.size() != 8) begin
      n_fail++;
      $display("FAIL rst_resume_count: got %0d expected 8", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_odd_href();
    test_random_windows();
    test_cap_drop();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov5640_capture.md
OV5640_CAPTURE -- requirements
Module: ov5640_capture

Interface
REQ-001 SHALL have parameter PIX_BYTES, default 2; bytes per pixel, legal values 1..4.
REQ-002 SHALL have parameter SKIP_FRAMES, default 10; frames discarded after reset, range 0..255.
REQ-003 SHALL have parameter CNT_W, default 12; width of the pixel/line counters and window configuration ports.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 places the first byte of a pixel in the top byte of m_data, 0 in the bottom byte.
REQ-005 SHALL have port ov5640_pclk, input, 1; sole clock, all logic on rising edge.
REQ-006 SHALL have port s_rst_n, input, 1; asynchronous active-low reset.
REQ-007 SHALL have port ov5640_href, input, 1; line valid.
REQ-008 SHALL have port ov5640_vsync, input, 1; frame sync, rising edge marks frame boundary.
REQ-009 SHALL have port ov5640_data, input, 8; sensor byte.
REQ-010 SHALL have port cap_en, input, 1; capture enable.
REQ-011 SHALL have ports cfg_x_start, cfg_x_size, cfg_y_start, cfg_y_size, input, CNT_W each; crop window in pixels/lines.
REQ-012 SHALL have port m_data, output, 8*PIX_BYTES; assembled pixel.
REQ-013 SHALL have port m_wr_en, output, 1; one-cycle pixel valid strobe.
REQ-014 SHALL have port m_sof, output, 1; high with the first m_wr_en of a frame.
REQ-015 SHALL have port m_eol, output, 1; high with the last m_wr_en of each window line.
REQ-016 SHALL have port frame_done, output, 1; one-cycle pulse at the end of a captured frame.
REQ-017 SHALL have port busy, output, 1; high in state ACTIVE.

Function
REQ-018 SHALL detect the vsync rising edge (vs_pos) as current vsync high and previous-cycle vsync low.
REQ-019 SHALL implement states SKIP, IDLE, WAIT_VS, ACTIVE.
REQ-020 SHALL enter SKIP on reset, count vs_pos, and move to IDLE after SKIP_FRAMES edges; with SKIP_FRAMES=0 it SHALL move to IDLE on the first cycle after reset.
REQ-021 SHALL go IDLE->WAIT_VS when cap_en=1, WAIT_VS->ACTIVE on vs_pos, and WAIT_VS->IDLE if cap_en drops first.
REQ-022 SHALL, in ACTIVE on vs_pos, pulse frame_done, then stay in ACTIVE if cap_en=1, else go to IDLE; cap_en dropping mid-frame SHALL NOT truncate the frame.
REQ-023 SHALL keep a byte index that counts 0..PIX_BYTES-1 while href=1, wraps to 0, and is forced to 0 while href=0; a partial pixel at href fall SHALL be discarded.
REQ-024 SHALL shift each byte into the pixel register at the position given by its byte index and MSB_FIRST.
REQ-025 SHALL complete a pixel on the edge that samples byte index PIX_BYTES-1; m_data and m_wr_en SHALL be valid on the following cycle (1-cycle latency), with m_wr_en high for exactly 1 cycle.
REQ-026 SHALL keep x_cnt, the pixel index within the line, which increments per completed pixel, clears on href falling edge, and saturates at 2^CNT_W-1.
REQ-027 SHALL keep y_cnt, the line index, which increments on each href falling edge, clears on vs_pos, and saturates at 2^CNT_W-1.
REQ-028 SHALL assert m_wr_en only in ACTIVE, when cfg_x_start <= x_cnt < cfg_x_start+cfg_x_size and cfg_y_start <= y_cnt < cfg_y_start+cfg_y_size, with the sums computed at CNT_W+1 bits.
REQ-029 SHALL produce no m_wr_en for the whole frame when cfg_x_size=0 or cfg_y_size=0.
REQ-030 SHALL assert m_sof on the first m_wr_en after entering ACTIVE or after vs_pos.
REQ-031 SHALL assert m_eol when x_cnt = cfg_x_start+cfg_x_size-1.
REQ-032 SHALL sample the cfg_* ports on vs_pos only, so a change takes effect at the next frame.
REQ-033 SHALL, when vs_pos and a pixel completion fall in the same cycle, process the completion against the old frame's counters first.

Reset
REQ-034 SHALL, while s_rst_n=0, drive m_data=0, m_wr_en=0, m_sof=0, m_eol=0, frame_done=0, busy=0, clear all counters, the byte index and the latched configuration, and set state=SKIP.
REQ-035 SHALL, on reset asserted mid-frame, apply reset values immediately and, after release, re-run the full SKIP_FRAMES skip.
REQ-036 SHALL also reset the vsync edge register, so vsync held high at reset release is not detected as vs_pos.

Verification
REQ-037 Bench SHALL check: PIX_BYTES=2, MSB_FIRST=1, SKIP_FRAMES=2, window 0/4 x 0/2, bytes 0x12,0x34,... -> nothing output for frames 1-2; frame 3 gives 8 writes, first m_data=0x1234 with m_sof, m_eol on pixel 3 of each line, frame_done at the next vs_pos.
REQ-038 Bench SHALL check: MSB_FIRST=0, same bytes -> m_data=0x3412.
REQ-039 Bench SHALL check: window x_start=2, x_size=3, y_start=1, y_size=1 on an 8x4 frame -> exactly 3 writes, all from line 1, pixels 2..4.
REQ-040 Bench SHALL check: href dropped after an odd byte count (PIX_BYTES=2) -> last byte discarded and the next line starts at byte index 0.
REQ-041 Bench SHALL check: cap_en deasserted mid-frame -> remaining window pixels still written, frame_done pulses, busy=0 on the cycle after, and no writes in the next frame.
REQ-042 Bench SHALL check: s_rst_n pulsed low mid-line -> all outputs 0 within the reset, then SKIP_FRAMES frames skipped before writes resume.
